// File: rtl/mux_scan_pkg.sv
// Shared mode encodings and a constant clog2 helper for the scanning selector.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_timer.sv
// Dwell counter for scan mode: tick marks the last cycle of a channel's dwell.
// Combinational tick, registered count; en=0 freezes the count, clr forces it to 0.
module scan_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? clog2(DWELL) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DWELL - 1)) & en;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// NCH-to-1 selector with registered output; manual select or automatic scan with DWELL cycles per channel.
// Latency d->y one cycle; hold freezes ch/y/dwell, no other backpressure.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    parameter int SEL_W = clog2(NCH),
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    input  logic                 hold,
    output logic [WIDTH-1:0]     y,
    output logic [SEL_W-1:0]     ch,
    output logic                 y_valid,
    output logic                 wrap,
    output logic                 sel_err
);

    logic             tick;
    logic             sel_bad;
    logic             last_ch;
    logic [SEL_W-1:0] next_ch;

    // Manual mode keeps the dwell count cleared so a later switch to scan starts a full dwell.
    scan_timer #(.DWELL(DWELL)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   ((mode == MODE_SCAN) && !hold),
        .clr  ((mode == MODE_MANUAL) && !hold),
        .tick (tick)
    );

    assign last_ch = (ch == SEL_W'(NCH - 1));
    assign sel_bad = (mode == MODE_MANUAL) && (int'(sel) >= NCH);

    always_comb begin
        next_ch = ch;
        if (mode == MODE_MANUAL) begin
            if (!sel_bad) next_ch = sel;
        end else if (tick) begin
            next_ch = last_ch ? '0 : ch + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            ch      <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            y_valid <= 1'b1;
            if (hold) begin
                wrap    <= 1'b0;
                sel_err <= 1'b0;
            end else begin
                ch      <= next_ch;
                y       <= d[int'(next_ch)*WIDTH +: WIDTH];
                wrap    <= tick && last_ch;
                sel_err <= sel_bad;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Three selector configurations driven in lockstep and checked against a per-cycle reference model.
module tb_mux_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d8;
    logic [1:0] sel;
    logic       mode;
    logic       hold;

    logic [1:0] o_y  [3];
    logic [1:0] o_ch [3];
    logic       o_v  [3];
    logic       o_w  [3];
    logic       o_e  [3];

    always #5 clk = ~clk;

    mux_scan #(.WIDTH(2), .NCH(4), .DWELL(4)) u_base (
        .clk(clk), .rst(rst), .d(d8), .sel(sel), .mode(mode), .hold(hold),
        .y(o_y[0]), .ch(o_ch[0]), .y_valid(o_v[0]), .wrap(o_w[0]), .sel_err(o_e[0])
    );

    mux_scan #(.WIDTH(2), .NCH(3), .DWELL(4)) u_nch3 (
        .clk(clk), .rst(rst), .d(d8[5:0]), .sel(sel), .mode(mode), .hold(hold),
        .y(o_y[1]), .ch(o_ch[1]), .y_valid(o_v[1]), .wrap(o_w[1]), .sel_err(o_e[1])
    );

    mux_scan #(.WIDTH(2), .NCH(4), .DWELL(1)) u_dw1 (
        .clk(clk), .rst(rst), .d(d8), .sel(sel), .mode(mode), .hold(hold),
        .y(o_y[2]), .ch(o_ch[2]), .y_valid(o_v[2]), .wrap(o_w[2]), .sel_err(o_e[2])
    );

    int nch [3] = '{4, 3, 4};
    int dw  [3] = '{4, 4, 1};

    // Model state: current channel, edges already spent on it, and the registered outputs.
    int m_ch [3], m_pos [3], m_y [3], m_v [3], m_w [3], m_e [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int chan_val(input int k);
        return (int'(d8) >> (2 * k)) & 3;
    endfunction

    task automatic model_edge(input int i);
        if (rst) begin
            m_ch[i] = 0; m_pos[i] = 0; m_y[i] = 0; m_v[i] = 0; m_w[i] = 0; m_e[i] = 0;
            return;
        end
        m_v[i] = 1;
        m_w[i] = 0;
        m_e[i] = 0;
        if (hold) return;
        if (!mode) begin
            m_pos[i] = 0;
            if (int'(sel) < nch[i]) m_ch[i] = int'(sel);
            else m_e[i] = 1;
        end else begin
            m_pos[i]++;
            if (m_pos[i] == dw[i]) begin
                m_pos[i] = 0;
                m_w[i]  = (m_ch[i] == nch[i] - 1) ? 1 : 0;
                m_ch[i] = (m_ch[i] + 1) % nch[i];
            end
        end
        m_y[i] = chan_val(m_ch[i]);
    endtask

    task automatic step();
        for (int i = 0; i < 3; i++) model_edge(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_y", i),       32'(o_y[i]),  m_y[i]);
            chk($sformatf("u%0d_ch", i),      32'(o_ch[i]), m_ch[i]);
            chk($sformatf("u%0d_y_valid", i), 32'(o_v[i]),  m_v[i]);
            chk($sformatf("u%0d_wrap", i),    32'(o_w[i]),  m_w[i]);
            chk($sformatf("u%0d_sel_err", i), 32'(o_e[i]),  m_e[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int wraps;
        rst = 1'b1; d8 = 8'h00; sel = 2'd0; mode = 1'b0; hold = 1'b0;
        @(negedge clk);

        // Reset and manual selection.
        do_reset();
        chk("t1_rst_ch", 32'(o_ch[0]), 0);
        chk("t1_rst_valid", 32'(o_v[0]), 0);
        d8 = 8'b11_10_01_00; sel = 2'd2;
        step();
        chk("t1_ch", 32'(o_ch[0]), 2);
        chk("t1_y", 32'(o_y[0]), 2);
        chk("t1_valid", 32'(o_v[0]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t1_rst_y", 32'(o_y[0]), 0);
        chk("t1_rst_ch2", 32'(o_ch[0]), 0);
        chk("t1_rst_valid2", 32'(o_v[0]), 0);

        // Full scan rotation with a single wrap.
        mode = 1'b1;
        wraps = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("t2_ch_e%0d", k), 32'(o_ch[0]), (k / 4) % 4);
            if (o_w[0]) wraps++;
        end
        chk("t2_wraps", 32'(wraps), 1);

        // Out-of-range select on the 3-channel instance.
        mode = 1'b0; sel = 2'd1;
        step();
        sel = 2'd3;
        step();
        chk("t3_ch_kept", 32'(o_ch[1]), 1);
        chk("t3_sel_err", 32'(o_e[1]), 1);
        sel = 2'd0;
        step();
        chk("t3_ch_zero", 32'(o_ch[1]), 0);
        chk("t3_sel_err_clr", 32'(o_e[1]), 0);

        // Hold mid-dwell.
        do_reset();
        mode = 1'b1; d8 = 8'b11_10_01_00;
        step(); step();
        hold = 1'b1;
        d8 = 8'b11_10_01_11;
        for (int k = 0; k < 5; k++) step();
        chk("t4_ch_frozen", 32'(o_ch[0]), 0);
        chk("t4_y_frozen", 32'(o_y[0]), 0);
        hold = 1'b0;
        step();
        chk("t4_ch_rel1", 32'(o_ch[0]), 0);
        step();
        chk("t4_ch_rel2", 32'(o_ch[0]), 1);

        // Live data tracking within a dwell, and DWELL=1 rotation.
        do_reset();
        mode = 1'b1; d8 = 8'h00;
        step();
        d8 = 8'h03;
        step();
        chk("t5_y_live", 32'(o_y[0]), 3);
        chk("t5_ch_same", 32'(o_ch[0]), 0);
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("t5_dw1_ch_e%0d", k), 32'(o_ch[2]), k % 4);
        end

        // Reset in the middle of a dwell on the last channel.
        do_reset();
        d8 = 8'b11_10_01_01;
        for (int k = 0; k < 14; k++) step();
        chk("t6_pre_ch", 32'(o_ch[0]), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_ch", 32'(o_ch[0]), 0);
        chk("t6_rst_y", 32'(o_y[0]), 0);
        chk("t6_rst_valid", 32'(o_v[0]), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("t6_restart_e%0d", k), 32'(o_ch[0]), k / 4);
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst  = ($urandom_range(0, 39) == 0);
            hold = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel  = 2'($urandom);
            d8   = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
